// File: rtl/bsg_dlatch_launch.sv
// Registers a handshaked word and launches it into a level-sensitive latch bank with a
// programmable setup/open/hold enable window. Optional parity output: BSG_DLATCH_LAUNCH_PARITY_EN.
module bsg_dlatch_launch #(
   parameter int unsigned width_p        = 16,
   parameter int unsigned setup_cycles_p = 1,
   parameter int unsigned open_cycles_p  = 1,
   parameter int unsigned hold_cycles_p  = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic [width_p-1:0] data_o,
   output logic               latch_en_o,
`ifdef BSG_DLATCH_LAUNCH_PARITY_EN
   output logic               parity_o,
`endif
   output logic               done_o
);

   localparam int unsigned MaxSo     = (setup_cycles_p > open_cycles_p) ? setup_cycles_p
                                                                        : open_cycles_p;
   localparam int unsigned MaxCycles = (MaxSo > hold_cycles_p) ? MaxSo : hold_cycles_p;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] OPEN  = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   localparam logic [CntW-1:0] SetupLoad = CntW'(setup_cycles_p - 1);
   localparam logic [CntW-1:0] OpenLoad  = CntW'(open_cycles_p - 1);
   localparam logic [CntW-1:0] HoldLoad  = CntW'(hold_cycles_p - 1);

   logic [1:0]         r_state, w_state_n;
   logic [CntW-1:0]    r_cnt, w_cnt_n;
   logic [width_p-1:0] r_data;
   logic               r_latch_en, w_latch_en_n;
   logic               r_done, w_done_n;
   logic               w_xfer;

   assign ready_o    = (r_state == IDLE) & ~reset_i;
   assign w_xfer     = v_i & ready_o;
   assign data_o     = r_data;
   assign latch_en_o = r_latch_en;
   assign done_o     = r_done;

   always_comb begin
      w_state_n    = r_state;
      w_cnt_n      = r_cnt;
      w_latch_en_n = r_latch_en;
      w_done_n     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_xfer) begin
               w_state_n = SETUP;
               w_cnt_n   = SetupLoad;
            end
         end
         SETUP: begin
            if (r_cnt == '0) begin
               w_state_n    = OPEN;
               w_cnt_n      = OpenLoad;
               w_latch_en_n = 1'b1;
            end else begin
               w_cnt_n = r_cnt - CntW'(1);
            end
         end
         OPEN: begin
            if (r_cnt == '0) begin
               w_state_n    = HOLD;
               w_cnt_n      = HoldLoad;
               w_latch_en_n = 1'b0;
            end else begin
               w_cnt_n = r_cnt - CntW'(1);
            end
         end
         HOLD: begin
            if (r_cnt == '0) begin
               w_state_n = IDLE;
               w_done_n  = 1'b1;
            end else begin
               w_cnt_n = r_cnt - CntW'(1);
            end
         end
         default: begin
            w_state_n    = IDLE;
            w_cnt_n      = '0;
            w_latch_en_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_latch_en <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_cnt      <= w_cnt_n;
         r_latch_en <= w_latch_en_n;
         r_done     <= w_done_n;
      end
   end

   // The word only moves on a transfer edge, so it is stable across the whole window.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_data <= '0;
      end else if (w_xfer) begin
         r_data <= data_i;
      end
   end

`ifdef BSG_DLATCH_LAUNCH_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_parity <= 1'b0;
      end else if (w_xfer) begin
         r_parity <= ^data_i;
      end
   end

   assign parity_o = r_parity;
`endif

endmodule

// File: tb/tb_bsg_dlatch_launch.sv
// Directed bench for bsg_dlatch_launch: default 1/1/1 instance plus a 2/3/2 stretched instance.
module tb_bsg_dlatch_launch;

   logic        clk;
   logic        rst;
   logic        v, v2;
   logic [15:0] d, d2;
   logic        ready, ready2;
   logic [15:0] dout, dout2;
   logic        len, len2;
   logic        done, done2;
`ifdef BSG_DLATCH_LAUNCH_PARITY_EN
   logic        par, par2;
`endif

   int n_vec = 0;
   int n_err = 0;

   bsg_dlatch_launch #(
      .width_p(16), .setup_cycles_p(1), .open_cycles_p(1), .hold_cycles_p(1)
   ) dut (
      .clk_i(clk), .reset_i(rst), .v_i(v), .data_i(d), .ready_o(ready), .data_o(dout),
      .latch_en_o(len),
`ifdef BSG_DLATCH_LAUNCH_PARITY_EN
      .parity_o(par),
`endif
      .done_o(done)
   );

   bsg_dlatch_launch #(
      .width_p(16), .setup_cycles_p(2), .open_cycles_p(3), .hold_cycles_p(2)
   ) dut2 (
      .clk_i(clk), .reset_i(rst), .v_i(v2), .data_i(d2), .ready_o(ready2), .data_o(dout2),
      .latch_en_o(len2),
`ifdef BSG_DLATCH_LAUNCH_PARITY_EN
      .parity_o(par2),
`endif
      .done_o(done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst = 1'b1; v = 1'b1; d = 16'hFFFF; v2 = 1'b0; d2 = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
      n_vec++; if (dout !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h want 0000", dout); end
      n_vec++; if (len !== 1'b0) begin n_err++; $display("FAIL reset_len: got %b want 0", len); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      rst = 1'b0;
      #1;
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", ready); end
      @(posedge clk); #1;
      n_vec++; if (dout !== 16'hFFFF) begin n_err++; $display("FAIL pre_reset_data: got %h want ffff", dout); end
      // Mid-cycle assertion with a word already launched must clear everything at once.
      #3 rst = 1'b1;
      #1;
      n_vec++; if (dout !== 16'h0) begin n_err++; $display("FAIL async_data: got %h want 0000", dout); end
      n_vec++; if (len !== 1'b0) begin n_err++; $display("FAIL async_len: got %b want 0", len); end
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL async_ready: got %b want 0", ready); end
      @(posedge clk); #1;
      rst = 1'b0; v = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", ready); end
   endtask

   task automatic test_single();
      v = 1'b1; d = 16'hA5C3;
      @(posedge clk); #1;
      v = 1'b0; d = 16'h0000;
      n_vec++; if (dout !== 16'hA5C3) begin n_err++; $display("FAIL single_data: got %h want a5c3", dout); end
      n_vec++; if (len !== 1'b0) begin n_err++; $display("FAIL single_len_t0: got %b want 0", len); end
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL single_ready_t0: got %b want 0", ready); end
      @(posedge clk); #1;
      n_vec++; if (len !== 1'b1) begin n_err++; $display("FAIL single_len_t1: got %b want 1", len); end
      @(posedge clk); #1;
      n_vec++; if (len !== 1'b0) begin n_err++; $display("FAIL single_len_t2: got %b want 0", len); end
      n_vec++; if (dout !== 16'hA5C3) begin n_err++; $display("FAIL single_data_hold: got %h want a5c3", dout); end
      @(posedge clk); #1;
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL single_ready_t3: got %b want 1", ready); end
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL single_done_t3: got %b want 1", done); end
      @(posedge clk); #1;
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_t4: got %b want 0", done); end
      n_vec++; if (dout !== 16'hA5C3) begin n_err++; $display("FAIL single_data_idle: got %h want a5c3", dout); end
   endtask

   task automatic test_stretched();
      logic exp_len, exp_ready, exp_done;
      v2 = 1'b1; d2 = 16'h1234;
      @(posedge clk); #1;
      v2 = 1'b0; d2 = 16'hFFFF;
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         exp_len   = (k >= 2) && (k <= 4);
         exp_ready = (k >= 7);
         exp_done  = (k == 7);
         n_vec++; if (len2 !== exp_len) begin n_err++;
            $display("FAIL stretch_len k=%0d: got %b want %b", k, len2, exp_len); end
         n_vec++; if (ready2 !== exp_ready) begin n_err++;
            $display("FAIL stretch_ready k=%0d: got %b want %b", k, ready2, exp_ready); end
         n_vec++; if (done2 !== exp_done) begin n_err++;
            $display("FAIL stretch_done k=%0d: got %b want %b", k, done2, exp_done); end
         n_vec++; if (dout2 !== 16'h1234) begin n_err++;
            $display("FAIL stretch_data k=%0d: got %h want 1234", k, dout2); end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_data [8];
      logic        exp_len  [8];
      logic        exp_done [8];
      exp_data = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'h0002, 16'h0002};
      exp_len  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      v = 1'b1; d = 16'h0001;
      @(posedge clk); #1;
      d = 16'h0002;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         if (k == 4) v = 1'b0;
         n_vec++; if (dout !== exp_data[k]) begin n_err++;
            $display("FAIL b2b_data k=%0d: got %h want %h", k, dout, exp_data[k]); end
         n_vec++; if (len !== exp_len[k]) begin n_err++;
            $display("FAIL b2b_len k=%0d: got %b want %b", k, len, exp_len[k]); end
         n_vec++; if (done !== exp_done[k]) begin n_err++;
            $display("FAIL b2b_done k=%0d: got %b want %b", k, done, exp_done[k]); end
      end
   endtask

   task automatic test_reset_open();
      v = 1'b1; d = 16'h5555;
      @(posedge clk); #1;
      v = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (len !== 1'b1) begin n_err++; $display("FAIL ro_len_open: got %b want 1", len); end
      #2 rst = 1'b1;
      #1;
      n_vec++; if (len !== 1'b0) begin n_err++; $display("FAIL ro_len: got %b want 0", len); end
      n_vec++; if (dout !== 16'h0) begin n_err++; $display("FAIL ro_data: got %h want 0000", dout); end
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL ro_ready: got %b want 0", ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL ro_no_done k=%0d: got %b want 0", k, done); end
      end
      v = 1'b1; d = 16'hBEEF;
      @(posedge clk); #1;
      v = 1'b0;
      n_vec++; if (dout !== 16'hBEEF) begin n_err++; $display("FAIL ro_next_data: got %h want beef", dout); end
      @(posedge clk); #1;
      n_vec++; if (len !== 1'b1) begin n_err++; $display("FAIL ro_next_len: got %b want 1", len); end
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL ro_next_done: got %b want 1", done); end
   endtask

`ifdef BSG_DLATCH_LAUNCH_PARITY_EN
   task automatic test_parity();
      logic [15:0] words [2];
      logic        exp_p [2];
      words = '{16'h0007, 16'h0003};
      exp_p = '{1'b1, 1'b0};
      for (int w = 0; w < 2; w++) begin
         v = 1'b1; d = words[w];
         @(posedge clk); #1;
         v = 1'b0; d = 16'hFFFE;
         for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
               @(posedge clk); #1;
            end
            n_vec++; if (par !== exp_p[w]) begin n_err++;
               $display("FAIL parity w=%0d k=%0d: got %b want %b", w, k, par, exp_p[w]); end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_stretched();
      test_back_to_back();
      test_reset_open();
`ifdef BSG_DLATCH_LAUNCH_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
